fixed_adder_arbiter: RTL and testbench

//   Shares one sign-magnitude fixed-point adder (fixed_adder2) between NREQ requesters,
//   e.g. the v/u update lanes of the neuron engine.

---
 rtl/fixed_adder_arbiter_if.sv | 29 ++
 rtl/fixed_adder_arbiter.sv | 127 ++++++++++++
 tb/tb_fixed_adder_arbiter.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fixed_adder_arbiter_if.sv
// Request/response bundle between NREQ adder clients and the shared adder pipeline.
// master = clients/consumer side, slave = arbiter.
interface fixed_adder_arbiter_if #(
  parameter int NUMWIDTH = 16,
  parameter int NREQ     = 4,
  parameter int IDW      = 2
);
  logic [NREQ-1:0]              req_valid;
  logic [NREQ-1:0]              req_ready;
  logic [NREQ*(NUMWIDTH+1)-1:0] req_a;
  logic [NREQ*(NUMWIDTH+1)-1:0] req_b;
  logic [NREQ-1:0]              req_sub;
  logic                         rsp_valid;
  logic                         rsp_ready;
  logic [IDW-1:0]               rsp_id;
  logic [NUMWIDTH:0]            rsp_sum;
  logic                         rsp_ovf;
  logic                         busy;

  modport master (
    output req_valid, req_a, req_b, req_sub, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_ovf, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sub, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_ovf, busy
  );
endinterface

// File: rtl/fixed_adder_arbiter.sv
// Round-robin share of one sign-magnitude adder; result valid 2 edges after grant, 1 op/cycle.
// A stalled response holds RSP and S1 stable; req_ready is all-zero while S1 cannot accept.
module fixed_adder_arbiter #(
  parameter int NUMWIDTH = 16,
  parameter int NREQ     = 4,
  parameter int IDW      = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  fixed_adder_arbiter_if.slave bus
);
  localparam int W = NUMWIDTH + 1;

  typedef struct packed {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           sub;
    logic [IDW-1:0] id;
  } op_t;

  op_t               s1_op;
  op_t               grant_op;
  logic              s1_v;
  logic [IDW-1:0]    rr_ptr;
  logic [IDW-1:0]    grant_id;
  logic [IDW-1:0]    next_ptr;
  logic              grant_vld;
  logic              s1_free;
  logic              adv2;
  logic              hs;
  logic [2*NREQ-1:0] rot;
  int                gsel;

  logic                sa, sb, eff_add, sgn, ovf;
  logic [NUMWIDTH-1:0] ma, mb, mag;
  logic [NUMWIDTH:0]   wide;
  logic [W-1:0]        sum;

  assign adv2    = s1_v & (~bus.rsp_valid | bus.rsp_ready);
  assign s1_free = ~s1_v | adv2;
  assign hs      = s1_free & grant_vld;

  // Rotating the doubled request vector by rr_ptr puts the search origin at bit 0.
  always_comb begin
    rot       = {bus.req_valid, bus.req_valid} >> rr_ptr;
    grant_vld = 1'b0;
    gsel      = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        grant_vld = 1'b1;
        gsel      = int'(rr_ptr) + k;
      end
    end
    if (gsel >= NREQ) gsel = gsel - NREQ;
    grant_id = IDW'(gsel);
    next_ptr = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
  end

  always_comb begin
    grant_op = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id == IDW'(i)) begin
        grant_op.a   = bus.req_a[i*W +: W];
        grant_op.b   = bus.req_b[i*W +: W];
        grant_op.sub = bus.req_sub[i];
      end
    end
    grant_op.id = grant_id;
  end

  always_comb begin
    bus.req_ready = '0;
    if (hs) bus.req_ready[grant_id] = 1'b1;
  end

  // Sign-magnitude add/sub from the S1 registers.
  always_comb begin
    sa      = s1_op.a[NUMWIDTH];
    sb      = s1_op.b[NUMWIDTH];
    ma      = s1_op.a[NUMWIDTH-1:0];
    mb      = s1_op.b[NUMWIDTH-1:0];
    eff_add = s1_op.sub ? (sa != sb) : (sa == sb);
    wide    = {1'b0, ma} + {1'b0, mb};
    ovf     = 1'b0;
    sgn     = sa;
    mag     = '0;
    if (eff_add) begin
      mag = wide[NUMWIDTH-1:0];
      ovf = wide[NUMWIDTH];
    end else if (ma > mb) begin
      mag = ma - mb;
    end else if (mb > ma) begin
      mag = mb - ma;
      sgn = s1_op.sub ? ~sa : sb;
    end
    if (mag == '0) sgn = 1'b0;
    sum = {sgn, mag};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v          <= 1'b0;
      s1_op         <= '0;
      rr_ptr        <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_sum   <= '0;
      bus.rsp_ovf   <= 1'b0;
    end else begin
      if (adv2) begin
        bus.rsp_valid <= 1'b1;
        bus.rsp_id    <= s1_op.id;
        bus.rsp_sum   <= sum;
        bus.rsp_ovf   <= ovf;
      end else if (bus.rsp_ready) begin
        bus.rsp_valid <= 1'b0;
      end
      if (s1_free) s1_v <= hs;
      if (hs) begin
        s1_op  <= grant_op;
        rr_ptr <= next_ptr;
      end
    end
  end

  assign bus.busy = s1_v | bus.rsp_valid;
endmodule

// File: tb/tb_fixed_adder_arbiter.sv
// Bench for fixed_adder_arbiter: directed cases plus random traffic against a signed-integer model.
module tb_fixed_adder_arbiter;
  localparam int NUMWIDTH = 16;
  localparam int NREQ     = 4;
  localparam int IDW      = 2;
  localparam int W        = NUMWIDTH + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fixed_adder_arbiter_if #(.NUMWIDTH(NUMWIDTH), .NREQ(NREQ), .IDW(IDW)) bus ();

  fixed_adder_arbiter #(.NUMWIDTH(NUMWIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    int           id;
    logic [W-1:0] sum;
    logic         ovf;
    int           hs_edge;
  } exp_t;

  exp_t         q[$];
  int           checks   = 0;
  int           failures = 0;
  int           edge_n   = 0;
  int           nxt      = 0;
  logic         pend_v[NREQ];
  logic [W-1:0] pend_a[NREQ];
  logic [W-1:0] pend_b[NREQ];
  logic         pend_s[NREQ];
  int           last_grant;
  bit           rsp_seen;
  logic [W-1:0] last_sum;
  logic         last_ovf;
  int           last_id;
  int           n_rsp = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Operands as signed integers; the magnitude wraps at 2^NUMWIDTH and zero is unsigned.
  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic sub);
    longint va, vb, r, m, lim;
    logic   o, s;
    lim = longint'(1) << NUMWIDTH;
    va  = longint'(a[NUMWIDTH-1:0]);
    vb  = longint'(b[NUMWIDTH-1:0]);
    if (a[NUMWIDTH]) va = -va;
    if (b[NUMWIDTH]) vb = -vb;
    r = sub ? va - vb : va + vb;
    m = (r < 0) ? -r : r;
    o = (m >= lim);
    m = m % lim;
    s = (r < 0) && (m != 0);
    return {o, s, m[NUMWIDTH-1:0]};
  endfunction

  function automatic logic [W-1:0] rnd_op();
    logic [NUMWIDTH-1:0] m;
    case ($urandom_range(0, 3))
      0:       m = '0;
      1:       m = '1;
      2:       m = NUMWIDTH'($urandom_range(0, 8));
      default: m = NUMWIDTH'($urandom);
    endcase
    return {1'($urandom_range(0, 1)), m};
  endfunction

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s);
    pend_v[i] = 1'b1;
    pend_a[i] = a;
    pend_b[i] = b;
    pend_s[i] = s;
  endtask

  task automatic clear_pend();
    for (int i = 0; i < NREQ; i++) pend_v[i] = 1'b0;
  endtask

  // One clock: drive, check outputs against the model, advance the model past the edge.
  task automatic cycle(input logic rready);
    logic [NREQ-1:0] exp_rdy;
    logic [W:0]      r;
    bit              head_vis, can_acc;
    int              g, idx;
    exp_t            e;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i]       = pend_v[i];
      bus.req_a[i*W +: W]    = pend_a[i];
      bus.req_b[i*W +: W]    = pend_b[i];
      bus.req_sub[i]         = pend_s[i];
    end
    bus.rsp_ready = rready;
    #1;
    head_vis = (q.size() > 0) && ((edge_n - q[0].hs_edge) >= 1);
    check("rsp_valid", {31'd0, bus.rsp_valid}, {31'd0, head_vis});
    check("busy", {31'd0, bus.busy}, {31'd0, q.size() > 0});
    if (head_vis) begin
      check("rsp_id", 32'(bus.rsp_id), 32'(q[0].id));
      check("rsp_sum", 32'(bus.rsp_sum), 32'(q[0].sum));
      check("rsp_ovf", {31'd0, bus.rsp_ovf}, {31'd0, q[0].ovf});
    end
    can_acc = (q.size() < 2) || (head_vis && rready);
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      idx = (nxt + k) % NREQ;
      if (g < 0 && pend_v[idx]) g = idx;
    end
    exp_rdy = '0;
    if (can_acc && g >= 0) exp_rdy[g] = 1'b1;
    check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    last_grant = -1;
    for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) last_grant = i;
    rsp_seen = bus.rsp_valid && rready;
    last_sum = bus.rsp_sum;
    last_ovf = bus.rsp_ovf;
    last_id  = int'(bus.rsp_id);
    if (rsp_seen) n_rsp++;
    if (head_vis && rready) void'(q.pop_front());
    if (exp_rdy != '0) begin
      r         = ref_add(pend_a[g], pend_b[g], pend_s[g]);
      e.id      = g;
      e.sum     = r[W-1:0];
      e.ovf     = r[W];
      e.hs_edge = edge_n + 1;
      q.push_back(e);
      nxt       = (g + 1) % NREQ;
      pend_v[g] = 1'b0;
    end
    @(posedge clk);
    edge_n++;
  endtask

  task automatic do_reset(input int ncyc);
    @(negedge clk);
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    repeat (ncyc) @(posedge clk);
    q.delete();
    nxt = 0;
    clear_pend();
    @(negedge clk);
    #1;
    check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    check("rst_rsp_sum", 32'(bus.rsp_sum), 32'd0);
    check("rst_rsp_ovf", {31'd0, bus.rsp_ovf}, 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic directed(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic [W-1:0] es, input logic eo);
    set_req(0, a, b, s);
    cycle(1'b1);
    check({tag, "_grant"}, 32'(last_grant), 32'd0);
    cycle(1'b1);
    check({tag, "_early"}, {31'd0, rsp_seen}, 32'd0);
    cycle(1'b1);
    check({tag, "_lat"}, {31'd0, rsp_seen}, 32'd1);
    check({tag, "_sum"}, 32'(last_sum), 32'(es));
    check({tag, "_ovf"}, {31'd0, last_ovf}, {31'd0, eo});
    check({tag, "_id"}, 32'(last_id), 32'd0);
  endtask

  initial begin
    int n0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_sub   = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      pend_v[i] = 1'b0;
      pend_a[i] = '0;
      pend_b[i] = '0;
      pend_s[i] = 1'b0;
    end
    do_reset(2);

    // All requesters saturated: strict rotation from requester 0.
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < NREQ; i++)
        if (!pend_v[i]) set_req(i, rnd_op(), rnd_op(), 1'($urandom_range(0, 1)));
      cycle(1'b1);
      check("t4_grant", 32'(last_grant), 32'(c % NREQ));
    end
    clear_pend();
    repeat (4) cycle(1'b1);

    directed("t1", 17'h00005, 17'h00003, 1'b0, 17'h00008, 1'b0);
    directed("t2a", 17'h00003, 17'h00005, 1'b1, 17'h10002, 1'b0);
    directed("t2b", 17'h10007, 17'h10007, 1'b1, 17'h00000, 1'b0);
    directed("t2c", 17'h10004, 17'h00009, 1'b0, 17'h00005, 1'b0);
    directed("t3a", 17'h0FFFF, 17'h00001, 1'b0, 17'h00000, 1'b1);
    directed("t3b", 17'h1FFFF, 17'h10001, 1'b0, 17'h00000, 1'b1);

    // Backpressure with three pending requests, then release.
    for (int i = 0; i < 3; i++) set_req(i, rnd_op(), rnd_op(), 1'($urandom_range(0, 1)));
    n0 = n_rsp;
    repeat (5) cycle(1'b0);
    check("t5_stall_grant", 32'(last_grant), 32'hFFFFFFFF);
    repeat (6) cycle(1'b1);
    check("t5_rsp_count", 32'(n_rsp - n0), 32'd3);

    // Reset with both stages occupied, then requesters 0 and 3 compete.
    set_req(1, rnd_op(), rnd_op(), 1'b0);
    set_req(2, rnd_op(), rnd_op(), 1'b1);
    cycle(1'b0);
    cycle(1'b0);
    do_reset(1);
    set_req(0, rnd_op(), rnd_op(), 1'b0);
    set_req(3, rnd_op(), rnd_op(), 1'b1);
    cycle(1'b1);
    check("t6_grant", 32'(last_grant), 32'd0);
    repeat (4) cycle(1'b1);

    // Random traffic, including dropped requests and response stalls.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend_v[i] && $urandom_range(0, 1) == 1) begin
          set_req(i, rnd_op(), rnd_op(), 1'($urandom_range(0, 1)));
          if ($urandom_range(0, 5) == 0)
            pend_b[i] = {1'($urandom_range(0, 1)), pend_a[i][NUMWIDTH-1:0]};
        end else if (pend_v[i] && $urandom_range(0, 15) == 0) begin
          pend_v[i] = 1'b0;
        end
      end
      cycle(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
    end

    clear_pend();
    repeat (6) cycle(1'b1);
    @(negedge clk);
    #1;
    check("end_busy", {31'd0, bus.busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
